// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among N_REQ requesters, with ID tagging of results.
// Define FP_ARB_OUT_REG_EN to register the response outputs (adds one cycle of response latency).

package struct_types;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;
endpackage

module fp_add_arbiter
    import struct_types::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 3,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [N_REQ-1:0]     req_vld_i,
    input  float_point_num       req_a_i [N_REQ],
    input  float_point_num       req_b_i [N_REQ],
    output logic [N_REQ-1:0]     req_rdy_o,
    output logic                 add_vld_o,
    output float_point_num       add_a_o,
    output float_point_num       add_b_o,
    input  logic                 add_vld_i,
    input  float_point_num       add_res_i,
    input  logic                 add_status_i,
    output logic                 rsp_vld_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output float_point_num       rsp_res_o,
    output logic                 rsp_status_o,
    output logic                 busy_o,
    output logic                 err_o
);

    logic [ID_W-1:0]              ptr_q, ptr_d;
    logic                         grant_vld;
    logic [ID_W-1:0]              grant_idx;
    logic [ID_W-1:0]              cand;

    logic                         add_vld_q, add_vld_d;
    float_point_num               add_a_q, add_a_d;
    float_point_num               add_b_q, add_b_d;
    logic [ID_W-1:0]              add_id_q, add_id_d;

    logic [ADD_LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [ADD_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic                         exp_vld;
    logic [ID_W-1:0]              exp_id;

    logic                         err_q, err_d;

    logic                         rsp_vld_d;
    logic [ID_W-1:0]              rsp_id_d;
    float_point_num               rsp_res_d;
    logic                         rsp_status_d;

    // Search starts at ptr and wraps; the first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_rdy_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr_q) + i >= N_REQ) ? ID_W'(int'(ptr_q) + i - N_REQ)
                                               : ID_W'(int'(ptr_q) + i);
            if (en_i && !grant_vld && req_vld_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            req_rdy_o[grant_idx] = 1'b1;
        end
    end

    assign exp_vld = tag_vld_q[ADD_LAT-1];
    assign exp_id  = tag_id_q[ADD_LAT-1];

    always_comb begin
        ptr_d     = ptr_q;
        add_vld_d = grant_vld;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_id_d  = add_id_q;
        if (grant_vld) begin
            ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            add_a_d  = req_a_i[grant_idx];
            add_b_d  = req_b_i[grant_idx];
            add_id_d = grant_idx;
        end

        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = add_vld_q;
        tag_id_d[0]  = add_id_q;
        for (int s = 1; s < ADD_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        err_d = err_q | (add_vld_i != exp_vld);
    end

    // Response fields are zeroed whenever no tracked result is due.
    always_comb begin
        rsp_vld_d    = exp_vld;
        rsp_id_d     = '0;
        rsp_res_d    = '0;
        rsp_status_d = 1'b0;
        if (exp_vld) begin
            rsp_id_d     = exp_id;
            rsp_res_d    = add_res_i;
            rsp_status_d = add_status_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            add_vld_q <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_id_q  <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            add_vld_q <= add_vld_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_id_q  <= add_id_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            err_q     <= err_d;
        end
    end

    assign add_vld_o = add_vld_q;
    assign add_a_o   = add_a_q;
    assign add_b_o   = add_b_q;
    assign err_o     = err_q;

`ifdef FP_ARB_OUT_REG_EN
    logic            rsp_vld_q;
    logic [ID_W-1:0] rsp_id_q;
    float_point_num  rsp_res_q;
    logic            rsp_status_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_res_q    <= '0;
            rsp_status_q <= 1'b0;
        end else begin
            rsp_vld_q    <= rsp_vld_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign rsp_vld_o    = rsp_vld_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_res_o    = rsp_res_q;
    assign rsp_status_o = rsp_status_q;
    assign busy_o       = add_vld_q | (|tag_vld_q) | rsp_vld_q;
`else
    assign rsp_vld_o    = rsp_vld_d;
    assign rsp_id_o     = rsp_id_d;
    assign rsp_res_o    = rsp_res_d;
    assign rsp_status_o = rsp_status_d;
    assign busy_o       = add_vld_q | (|tag_vld_q);
`endif

endmodule
